// File: rtl/record_reader.sv
// record_reader: steps or auto-plays through the packed result history.
// Define RECORD_READER_BEST_EN to add the best-time (minimum nonzero) scanner.
module record_reader #(
  parameter int NUM_REC = 9,
  parameter int REC_W   = 10,
  parameter int IDX_W   = 4,
  parameter int AUTO_MS = 1000
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     tick_1k,
  input  logic [NUM_REC*REC_W-1:0] store_in,
  input  logic [IDX_W-1:0]         rec_cnt,
  input  logic                     key_next,
  input  logic                     key_prev,
  input  logic                     key_auto,
`ifdef RECORD_READER_BEST_EN
  output logic [IDX_W-1:0]         best_idx,
  output logic [REC_W-1:0]         best_data,
`endif
  output logic [IDX_W-1:0]         rd_idx,
  output logic [REC_W-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     auto_on
);

  localparam int DW = (AUTO_MS > 1) ? $clog2(AUTO_MS) : 1;
  localparam logic [IDX_W-1:0] NUM_I  = IDX_W'(NUM_REC);
  localparam logic [IDX_W-1:0] ONE    = IDX_W'(1);
  localparam logic [DW-1:0]    DW_END = DW'(AUTO_MS - 1);
  localparam logic [DW-1:0]    DW_ONE = DW'(1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_BROWSE,
    S_AUTO
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] cnt_q, cnt_e, last;
  logic [IDX_W-1:0] base, nxt, prv;
  logic [REC_W-1:0] data_q, data_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic             valid_q, auto_q;
  logic             kn_q, kp_q, ka_q, arm_q;
  logic             en, ep, ea;
  logic [REC_W-1:0] slot [NUM_REC];

  for (genvar k = 0; k < NUM_REC; k++) begin : g_slot
    assign slot[k] = store_in[k*REC_W +: REC_W];
  end

  assign cnt_e = (rec_cnt > NUM_I) ? NUM_I : rec_cnt;
  assign last  = cnt_e - ONE;

  // arm_q masks the first cycle after reset so a held key never fires
  assign en = arm_q & key_next & ~kn_q;
  assign ep = arm_q & key_prev & ~kp_q;
  assign ea = arm_q & key_auto & ~ka_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = '0;
    base    = (idx_q > last) ? last : idx_q;
    if (state_q == S_BROWSE && cnt_e > cnt_q) base = last;
    nxt = (base == last) ? '0 : base + ONE;
    prv = (base == '0) ? last : base - ONE;
    unique case (state_q)
      S_EMPTY: begin
        if (cnt_e != '0) begin
          state_d = S_BROWSE;
          idx_d   = last;
        end
      end
      S_BROWSE: begin
        idx_d = base;
        if (en && !ep) idx_d = nxt;
        else if (ep && !en) idx_d = prv;
        if (ea) state_d = S_AUTO;
      end
      S_AUTO: begin
        idx_d   = base;
        dwell_d = dwell_q;
        if (en || ep || ea) begin
          state_d = S_BROWSE;
          dwell_d = '0;
          if (en && !ep) idx_d = nxt;
          else if (ep && !en) idx_d = prv;
        end else if (tick_1k) begin
          if (dwell_q == DW_END) begin
            idx_d   = nxt;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + DW_ONE;
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (cnt_e == '0) begin
      state_d = S_EMPTY;
      idx_d   = '0;
      dwell_d = '0;
    end
    data_d = '0;
    if (state_d != S_EMPTY && idx_q < NUM_I) data_d = slot[idx_q];
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= S_EMPTY;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      dwell_q <= '0;
      valid_q <= 1'b0;
      auto_q  <= 1'b0;
      kn_q    <= 1'b0;
      kp_q    <= 1'b0;
      ka_q    <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_e;
      data_q  <= data_d;
      dwell_q <= dwell_d;
      valid_q <= (state_d != S_EMPTY);
      auto_q  <= (state_d == S_AUTO);
      kn_q    <= key_next;
      kp_q    <= key_prev;
      ka_q    <= key_auto;
      arm_q   <= 1'b1;
    end
  end

  assign rd_idx   = idx_q;
  assign rd_data  = data_q;
  assign rd_valid = valid_q;
  assign auto_on  = auto_q;

`ifdef RECORD_READER_BEST_EN
  logic [IDX_W-1:0]         sc_i_q, mi_q, bi_q, sc_cnt_q;
  logic [REC_W-1:0]         mv_q, bv_q, sv;
  logic [NUM_REC*REC_W-1:0] st_q;
  logic                     hit, restart;

  assign sv  = (sc_i_q < NUM_I) ? slot[sc_i_q] : '0;
  assign hit = (sv != '0) && (mv_q == '0 || sv < mv_q);
  // any content or count change restarts the pass to bound result latency
  assign restart = (store_in != st_q) || (cnt_e != sc_cnt_q);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sc_i_q   <= '0;
      mi_q     <= '0;
      mv_q     <= '0;
      bi_q     <= '0;
      bv_q     <= '0;
      st_q     <= '0;
      sc_cnt_q <= '0;
    end else begin
      st_q     <= store_in;
      sc_cnt_q <= cnt_e;
      if (cnt_e == '0) begin
        sc_i_q <= '0;
        mi_q   <= '0;
        mv_q   <= '0;
        bi_q   <= '0;
        bv_q   <= '0;
      end else if (restart) begin
        sc_i_q <= '0;
        mi_q   <= '0;
        mv_q   <= '0;
      end else if (sc_i_q >= last) begin
        bi_q   <= hit ? sc_i_q : mi_q;
        bv_q   <= hit ? sv : mv_q;
        sc_i_q <= '0;
        mi_q   <= '0;
        mv_q   <= '0;
      end else begin
        sc_i_q <= sc_i_q + ONE;
        if (hit) begin
          mv_q <= sv;
          mi_q <= sc_i_q;
        end
      end
    end
  end

  assign best_idx  = bi_q;
  assign best_data = bv_q;
`endif

endmodule

// File: tb/tb_record_reader.sv
// tb_record_reader: directed self-checking bench for record_reader.
// Runs with AUTO_MS=4 so auto-play dwell is short.
module tb_record_reader;

  localparam int NUM_REC = 9;
  localparam int REC_W   = 10;
  localparam int IDX_W   = 4;
  localparam int AUTO_MS = 4;

  logic                     clk = 1'b0;
  logic                     clear;
  logic                     tick_1k;
  logic [NUM_REC*REC_W-1:0] store_in;
  logic [IDX_W-1:0]         rec_cnt;
  logic                     key_next, key_prev, key_auto;
  logic [IDX_W-1:0]         rd_idx;
  logic [REC_W-1:0]         rd_data;
  logic                     rd_valid, auto_on;
`ifdef RECORD_READER_BEST_EN
  logic [IDX_W-1:0]         best_idx;
  logic [REC_W-1:0]         best_data;
`endif

  int n_cmp = 0;
  int n_err = 0;

  record_reader #(
    .NUM_REC(NUM_REC),
    .REC_W  (REC_W),
    .IDX_W  (IDX_W),
    .AUTO_MS(AUTO_MS)
  ) dut (
    .clk      (clk),
    .clear    (clear),
    .tick_1k  (tick_1k),
    .store_in (store_in),
    .rec_cnt  (rec_cnt),
    .key_next (key_next),
    .key_prev (key_prev),
    .key_auto (key_auto),
`ifdef RECORD_READER_BEST_EN
    .best_idx (best_idx),
    .best_data(best_data),
`endif
    .rd_idx   (rd_idx),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .auto_on  (auto_on)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int k, input logic [REC_W-1:0] v);
    store_in[k*REC_W +: REC_W] = v;
  endtask

  task automatic tick();
    tick_1k = 1'b1;
    step();
    tick_1k = 1'b0;
    step();
  endtask

  task automatic test_reset();
    clear = 1'b1;
    step();
    step();
    n_cmp++;
    if (rd_idx !== 4'd0) begin
      n_err++;
      $display("FAIL reset_idx: got %0d want 0", rd_idx);
    end
    n_cmp++;
    if (rd_data !== 10'd0) begin
      n_err++;
      $display("FAIL reset_data: got %0d want 0", rd_data);
    end
    n_cmp++;
    if (rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid: got %b want 0", rd_valid);
    end
    n_cmp++;
    if (auto_on !== 1'b0) begin
      n_err++;
      $display("FAIL reset_auto: got %b want 0", auto_on);
    end
    clear = 1'b0;
    step();
    step();
  endtask

  task automatic test_empty_ignores_keys();
    key_next = 1'b1;
    key_auto = 1'b1;
    step();
    key_next = 1'b0;
    key_auto = 1'b0;
    step();
    n_cmp++;
    if (rd_valid !== 1'b0 || auto_on !== 1'b0 || rd_idx !== 4'd0) begin
      n_err++;
      $display("FAIL empty_keys: got v=%b a=%b i=%0d want v=0 a=0 i=0",
               rd_valid, auto_on, rd_idx);
    end
  endtask

  task automatic test_browse();
    set_slot(0, 10'd120);
    set_slot(1, 10'd95);
    set_slot(2, 10'd210);
    rec_cnt = 4'd3;
    step();
    n_cmp++;
    if (rd_idx !== 4'd2 || rd_valid !== 1'b1) begin
      n_err++;
      $display("FAIL browse_enter: got i=%0d v=%b want i=2 v=1", rd_idx, rd_valid);
    end
    step();
    n_cmp++;
    if (rd_data !== 10'd210) begin
      n_err++;
      $display("FAIL browse_enter_data: got %0d want 210", rd_data);
    end
    key_next = 1'b1;
    step();
    n_cmp++;
    if (rd_idx !== 4'd0) begin
      n_err++;
      $display("FAIL next_wrap_idx: got %0d want 0", rd_idx);
    end
    key_next = 1'b0;
    step();
    n_cmp++;
    if (rd_data !== 10'd120) begin
      n_err++;
      $display("FAIL next_wrap_data: got %0d want 120", rd_data);
    end
    key_prev = 1'b1;
    step();
    n_cmp++;
    if (rd_idx !== 4'd2) begin
      n_err++;
      $display("FAIL prev_wrap_idx: got %0d want 2", rd_idx);
    end
    key_prev = 1'b0;
    step();
    key_prev = 1'b1;
    step();
    n_cmp++;
    if (rd_idx !== 4'd1) begin
      n_err++;
      $display("FAIL prev_idx: got %0d want 1", rd_idx);
    end
    key_prev = 1'b0;
    step();
    n_cmp++;
    if (rd_data !== 10'd95) begin
      n_err++;
      $display("FAIL prev_data: got %0d want 95", rd_data);
    end
  endtask

  task automatic test_next_prev_same();
    key_next = 1'b1;
    key_prev = 1'b1;
    step();
    key_next = 1'b0;
    key_prev = 1'b0;
    step();
    n_cmp++;
    if (rd_idx !== 4'd1 || rd_data !== 10'd95) begin
      n_err++;
      $display("FAIL both_keys: got i=%0d d=%0d want i=1 d=95", rd_idx, rd_data);
    end
  endtask

  task automatic test_auto();
    rec_cnt = 4'd2;
    step();
    key_auto = 1'b1;
    step();
    n_cmp++;
    if (auto_on !== 1'b1 || rd_idx !== 4'd1) begin
      n_err++;
      $display("FAIL auto_enter: got a=%b i=%0d want a=1 i=1", auto_on, rd_idx);
    end
    key_auto = 1'b0;
    step();
    repeat (3) tick();
    n_cmp++;
    if (rd_idx !== 4'd1) begin
      n_err++;
      $display("FAIL auto_dwell3: got %0d want 1", rd_idx);
    end
    tick();
    n_cmp++;
    if (rd_idx !== 4'd0) begin
      n_err++;
      $display("FAIL auto_adv1: got %0d want 0", rd_idx);
    end
    repeat (4) tick();
    n_cmp++;
    if (rd_idx !== 4'd1 || auto_on !== 1'b1) begin
      n_err++;
      $display("FAIL auto_adv2: got i=%0d a=%b want i=1 a=1", rd_idx, auto_on);
    end
    repeat (2) tick();
    key_prev = 1'b1;
    step();
    n_cmp++;
    if (auto_on !== 1'b0 || rd_idx !== 4'd0) begin
      n_err++;
      $display("FAIL auto_prev_exit: got a=%b i=%0d want a=0 i=0", auto_on, rd_idx);
    end
    key_prev = 1'b0;
    step();
    repeat (4) tick();
    n_cmp++;
    if (rd_idx !== 4'd0 || rd_data !== 10'd120) begin
      n_err++;
      $display("FAIL browse_after_auto: got i=%0d d=%0d want i=0 d=120",
               rd_idx, rd_data);
    end
  endtask

  task automatic test_count_changes();
    set_slot(3, 10'd400);
    set_slot(4, 10'd500);
    rec_cnt = 4'd5;
    step();
    n_cmp++;
    if (rd_idx !== 4'd4) begin
      n_err++;
      $display("FAIL grow_jump: got %0d want 4", rd_idx);
    end
    step();
    n_cmp++;
    if (rd_data !== 10'd500) begin
      n_err++;
      $display("FAIL grow_data: got %0d want 500", rd_data);
    end
    rec_cnt = 4'd2;
    step();
    n_cmp++;
    if (rd_idx !== 4'd1) begin
      n_err++;
      $display("FAIL shrink_clamp: got %0d want 1", rd_idx);
    end
    step();
    n_cmp++;
    if (rd_data !== 10'd95) begin
      n_err++;
      $display("FAIL shrink_data: got %0d want 95", rd_data);
    end
    rec_cnt = 4'd0;
    step();
    n_cmp++;
    if (rd_valid !== 1'b0 || rd_idx !== 4'd0 || rd_data !== 10'd0) begin
      n_err++;
      $display("FAIL drop_empty: got v=%b i=%0d d=%0d want v=0 i=0 d=0",
               rd_valid, rd_idx, rd_data);
    end
    rec_cnt = 4'd12;
    step();
    n_cmp++;
    if (rd_idx !== 4'd8 || rd_valid !== 1'b1) begin
      n_err++;
      $display("FAIL cnt_sat: got i=%0d v=%b want i=8 v=1", rd_idx, rd_valid);
    end
    step();
    set_slot(8, 10'd888);
    step();
    n_cmp++;
    if (rd_data !== 10'd888) begin
      n_err++;
      $display("FAIL inplace_data: got %0d want 888", rd_data);
    end
  endtask

  task automatic test_clear_mid_auto();
    rec_cnt = 4'd5;
    step();
    key_auto = 1'b1;
    step();
    key_auto = 1'b0;
    step();
    n_cmp++;
    if (auto_on !== 1'b1 || rd_idx !== 4'd4) begin
      n_err++;
      $display("FAIL pre_clear_auto: got a=%b i=%0d want a=1 i=4", auto_on, rd_idx);
    end
    key_auto = 1'b1;
    #1;
    clear = 1'b1;
    #1;
    n_cmp++;
    if (rd_idx !== 4'd0 || rd_data !== 10'd0 || rd_valid !== 1'b0 ||
        auto_on !== 1'b0) begin
      n_err++;
      $display("FAIL async_clear: got i=%0d d=%0d v=%b a=%b want all 0",
               rd_idx, rd_data, rd_valid, auto_on);
    end
    step();
    step();
    clear = 1'b0;
    step();
    step();
    n_cmp++;
    if (auto_on !== 1'b0 || rd_valid !== 1'b1 || rd_idx !== 4'd4) begin
      n_err++;
      $display("FAIL held_key_release: got a=%b v=%b i=%0d want a=0 v=1 i=4",
               auto_on, rd_valid, rd_idx);
    end
    repeat (3) step();
    n_cmp++;
    if (auto_on !== 1'b0) begin
      n_err++;
      $display("FAIL held_key_later: got a=%b want 0", auto_on);
    end
    key_auto = 1'b0;
    step();
  endtask

`ifdef RECORD_READER_BEST_EN
  task automatic test_best();
    set_slot(0, 10'd0);
    set_slot(1, 10'd300);
    set_slot(2, 10'd150);
    set_slot(3, 10'd150);
    rec_cnt = 4'd4;
    repeat (NUM_REC + 2) step();
    n_cmp++;
    if (best_idx !== 4'd2 || best_data !== 10'd150) begin
      n_err++;
      $display("FAIL best_min: got i=%0d d=%0d want i=2 d=150",
               best_idx, best_data);
    end
    rec_cnt = 4'd0;
    step();
    step();
    n_cmp++;
    if (best_idx !== 4'd0 || best_data !== 10'd0) begin
      n_err++;
      $display("FAIL best_empty: got i=%0d d=%0d want 0", best_idx, best_data);
    end
  endtask
`endif

  initial begin
    clear    = 1'b1;
    tick_1k  = 1'b0;
    store_in = '0;
    rec_cnt  = '0;
    key_next = 1'b0;
    key_prev = 1'b0;
    key_auto = 1'b0;
    test_reset();
    test_empty_ignores_keys();
    test_browse();
    test_next_prev_same();
    test_auto();
    test_count_changes();
    test_clear_mid_auto();
`ifdef RECORD_READER_BEST_EN
    test_best();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
